// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader.
// Covers bus widths, UART register map, state encoding and the write-request payload.
package uart_loader_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 2;
  localparam int unsigned WCNT_W = 16;

  // UART register offsets from UART_BASE and the RX-ready flag in CTRL
  localparam logic [XLEN-1:0] UART_CTRL_OFS  = 32'h0000_0000;
  localparam logic [XLEN-1:0] UART_RXBUF_OFS = 32'h0000_0008;
  localparam int unsigned     UART_RI_BIT    = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POLL    = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_CLR_RI  = 3'd4,
    ST_STORE   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef struct packed {
    logic            en;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } bus_wr_t;

  // Drop one received byte into its little-endian lane of the assembly word
  function automatic logic [XLEN-1:0] lane_insert(input logic [XLEN-1:0]   word,
                                                  input logic [BCNT_W-1:0] lane,
                                                  input logic [BYTE_W-1:0] b);
    logic [XLEN-1:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_loader.sv
// Boot loader: pulls a length-prefixed little-endian word stream from a polled UART
// and writes it into instruction ROM while holding the core in reset.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [XLEN-1:0] UART_BASE = 32'h3000_0000,
  parameter int unsigned     ROM_WORDS = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en_i,
  output logic            uart_wr_en_o,
  output logic [XLEN-1:0] uart_wr_addr_o,
  output logic [XLEN-1:0] uart_wr_data_o,
  output logic [XLEN-1:0] uart_rd_addr_o,
  input  logic [XLEN-1:0] uart_rd_data_i,
  output logic            rom_wr_en_o,
  output logic [XLEN-1:0] rom_wr_addr_o,
  output logic [XLEN-1:0] rom_wr_data_o,
  output logic            hold_core_o,
  output logic            done_o,
  output logic            err_o
);

  state_e              state_q,    state_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WCNT_W-1:0]   word_inc;
  logic [XLEN-1:0]     word_num_q, word_num_d;
  logic [XLEN-1:0]     asm_q,      asm_d;
  logic [XLEN-1:0]     ctrl_q,     ctrl_d;
  logic [XLEN-1:0]     rd_addr_q,  rd_addr_d;
  logic                hdr_q,      hdr_d;
  logic                skip_q,     skip_d;
  logic                hold_q,     hold_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;
  bus_wr_t             uart_wr_q,  uart_wr_d;
  bus_wr_t             rom_wr_q,   rom_wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      word_num_q <= '0;
      asm_q      <= '0;
      ctrl_q     <= '0;
      rd_addr_q  <= '0;
      hdr_q      <= 1'b0;
      skip_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      uart_wr_q  <= '0;
      rom_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_num_q <= word_num_d;
      asm_q      <= asm_d;
      ctrl_q     <= ctrl_d;
      rd_addr_q  <= rd_addr_d;
      hdr_q      <= hdr_d;
      skip_q     <= skip_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      uart_wr_q  <= uart_wr_d;
      rom_wr_q   <= rom_wr_d;
    end
  end

  // Outputs are registered from the next state, so they line up with state_q.
  // The first CTRL sample after entering POLL belongs to an older read and is skipped.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    word_num_d = word_num_q;
    asm_d      = asm_q;
    ctrl_d     = ctrl_q;
    hdr_d      = hdr_q;
    skip_d     = skip_q;
    err_d      = err_q;
    uart_wr_d  = '0;
    rom_wr_d   = '0;
    word_inc   = word_cnt_q + WCNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (load_en_i) begin
          byte_cnt_d = '0;
          word_cnt_d = '0;
          word_num_d = '0;
          asm_d      = '0;
          hdr_d      = 1'b1;
          skip_d     = 1'b1;
          state_d    = ST_POLL;
        end
      end
      ST_POLL: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (uart_rd_data_i[UART_RI_BIT]) begin
          ctrl_d  = uart_rd_data_i;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        asm_d          = lane_insert(asm_q, byte_cnt_q, uart_rd_data_i[BYTE_W-1:0]);
        uart_wr_d.en   = 1'b1;
        uart_wr_d.addr = UART_BASE + UART_CTRL_OFS;
        uart_wr_d.data = ctrl_q;
        uart_wr_d.data[UART_RI_BIT] = 1'b0;
        state_d        = ST_CLR_RI;
      end
      ST_CLR_RI: begin
        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        if (byte_cnt_q == BCNT_W'(3)) begin
          state_d = ST_STORE;
          if (!hdr_q) begin
            rom_wr_d.en   = 1'b1;
            rom_wr_d.addr = {14'd0, word_cnt_q, 2'b00};
            rom_wr_d.data = asm_q;
          end
        end else begin
          skip_d  = 1'b1;
          state_d = ST_POLL;
        end
      end
      ST_STORE: begin
        skip_d = 1'b1;
        if (hdr_q) begin
          hdr_d      = 1'b0;
          word_num_d = asm_q;
          if (asm_q > XLEN'(ROM_WORDS)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (asm_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POLL;
          end
        end else begin
          word_cnt_d = word_inc;
          state_d    = (XLEN'(word_inc) == word_num_q) ? ST_DONE : ST_POLL;
        end
      end
      ST_DONE: begin
        if (!load_en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping load_en aborts from anywhere and cancels any pending strobe
    if (state_q != ST_IDLE && !load_en_i) begin
      state_d   = ST_IDLE;
      uart_wr_d = '0;
      rom_wr_d  = '0;
    end

    if (state_d == ST_IDLE) err_d = 1'b0;
    hold_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE) && !err_d;

    rd_addr_d = '0;
    if (state_d == ST_POLL)   rd_addr_d = UART_BASE + UART_CTRL_OFS;
    if (state_d == ST_RD_REQ) rd_addr_d = UART_BASE + UART_RXBUF_OFS;
  end

  assign uart_wr_en_o   = uart_wr_q.en;
  assign uart_wr_addr_o = uart_wr_q.addr;
  assign uart_wr_data_o = uart_wr_q.data;
  assign uart_rd_addr_o = rd_addr_q;
  assign rom_wr_en_o    = rom_wr_q.en;
  assign rom_wr_addr_o  = rom_wr_q.addr;
  assign rom_wr_data_o  = rom_wr_q.data;
  assign hold_core_o    = hold_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: a polled-UART model feeds byte streams; expected ROM writes
// are derived from the stream contents and checked every cycle.
module tb_uart_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en_i = 1'b0;
  logic        uart_wr_en_o;
  logic [31:0] uart_wr_addr_o, uart_wr_data_o, uart_rd_addr_o;
  logic [31:0] u_rd = 32'h0;
  logic        rom_wr_en_o;
  logic [31:0] rom_wr_addr_o, rom_wr_data_o;
  logic        hold_core_o, done_o, err_o;

  always #5 clk = ~clk;

  uart_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_en_i      (load_en_i),
    .uart_wr_en_o   (uart_wr_en_o),
    .uart_wr_addr_o (uart_wr_addr_o),
    .uart_wr_data_o (uart_wr_data_o),
    .uart_rd_addr_o (uart_rd_addr_o),
    .uart_rd_data_i (u_rd),
    .rom_wr_en_o    (rom_wr_en_o),
    .rom_wr_addr_o  (rom_wr_addr_o),
    .rom_wr_data_o  (rom_wr_data_o),
    .hold_core_o    (hold_core_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  // UART model: registered reads, CTRL writable, bytes delivered with random gaps
  logic [31:0] u_ctrl = 32'h0;
  logic [7:0]  u_rx = 8'h0;
  logic [7:0]  feed_mem [0:2047];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          gap = 0;
  logic        ti_force = 1'b0;

  always @(posedge clk) begin
    u_rd <= (uart_rd_addr_o == BASE) ? u_ctrl :
            (uart_rd_addr_o == BASE + 32'h8) ? {24'h0, u_rx} : 32'h0;
    if (uart_wr_en_o && uart_wr_addr_o == BASE) begin
      u_ctrl <= uart_wr_data_o;
    end else if (!u_ctrl[0] && rd_ptr != wr_ptr) begin
      if (gap > 0) begin
        gap <= gap - 1;
      end else begin
        u_rx   <= feed_mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
        u_ctrl <= {30'h0, ti_force | 1'($urandom), 1'b1};
        gap    <= int'($urandom_range(0, 5));
      end
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_addr [0:255];
  logic [31:0] exp_data [0:255];
  int          exp_wr = 0;
  int          exp_rd = 0;
  logic [31:0] log_addr [0:255];
  logic [31:0] log_data [0:255];
  int          log_n = 0;
  logic [31:0] last_uwr = 32'h0;
  logic [31:0] wv [0:15];
  logic        sim_end = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle checker; load_prev is the load_en value the DUT sampled at the last edge
  task automatic monitor();
    logic load_prev;
    load_prev = 1'b0;
    while (!sim_end) begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs_zero", 64'({uart_wr_en_o, rom_wr_en_o, hold_core_o, done_o, err_o}), 64'h0);
        chk("reset_buses_zero", 64'(uart_wr_addr_o | uart_wr_data_o | uart_rd_addr_o |
                                    rom_wr_addr_o | rom_wr_data_o), 64'h0);
      end else begin
        if (!load_prev)
          chk("idle_quiet", 64'({uart_wr_en_o, rom_wr_en_o, hold_core_o, done_o, err_o}), 64'h0);
        if (uart_wr_en_o || rom_wr_en_o)
          chk("strobe_exclusive", 64'(uart_wr_en_o & rom_wr_en_o), 64'h0);
        if (done_o || err_o)
          chk("hold_low_when_finished", 64'({hold_core_o, done_o & err_o}), 64'h0);
        if (uart_wr_en_o) begin
          chk("clr_ri_write", {uart_wr_addr_o, uart_wr_data_o}, {BASE, u_ctrl[31:1], 1'b0});
          last_uwr = uart_wr_data_o;
        end
        if (rom_wr_en_o) begin
          log_addr[log_n] = rom_wr_addr_o;
          log_data[log_n] = rom_wr_data_o;
          log_n++;
          if (exp_rd < exp_wr) begin
            chk("rom_write", {rom_wr_addr_o, rom_wr_data_o}, {exp_addr[exp_rd], exp_data[exp_rd]});
            exp_rd++;
          end else begin
            chk("unexpected_rom_write", 64'(1), 64'(0));
          end
        end
      end
      load_prev = load_en_i;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    feed_mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_byte(8'(w >> (8 * i)));
  endtask

  // Header n followed by nsend words from wv; words within range become expected writes
  task automatic stream(input logic [31:0] n, input int nsend);
    push_word(n);
    for (int i = 0; i < nsend; i++) begin
      push_word(wv[i]);
      if (n <= 32'd4096 && 32'(i) < n) begin
        exp_addr[exp_wr] = 32'(i) * 32'd4;
        exp_data[exp_wr] = wv[i];
        exp_wr++;
      end
    end
  endtask

  task automatic wait_quiet(input string name);
    int budget;
    budget = 1000;
    while ((rd_ptr != wr_ptr || u_ctrl[0]) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) chk({name, "_timeout"}, 64'(0), 64'(1));
    repeat (6) tick();
  endtask

  task automatic finish_load(input string name, input logic exp_done, input logic exp_err);
    int budget;
    budget = 3000;
    while (!(done_o || err_o) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) chk({name, "_timeout"}, 64'(0), 64'(1));
    chk({name, "_end_flags"}, 64'({done_o, err_o, hold_core_o}), 64'({exp_done, exp_err, 1'b0}));
    chk({name, "_writes_pending"}, 64'(exp_wr - exp_rd), 64'(0));
    load_en_i = 1'b0;
    repeat (3) tick();
    chk({name, "_flags_cleared"}, 64'({done_o, err_o, hold_core_o}), 64'(0));
  endtask

  task automatic stimulus();
    int b;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Literal stream: two words, pinned addresses and data
    b = log_n;
    wv[0] = 32'h1234_5678;
    wv[1] = 32'hDEAD_BEEF;
    load_en_i = 1'b1;
    stream(32'd2, 2);
    finish_load("two_words", 1'b1, 1'b0);
    chk("lit_count", 64'(log_n - b), 64'(2));
    chk("lit_w0", {log_addr[b], log_data[b]}, {32'h0, 32'h1234_5678});
    chk("lit_w1", {log_addr[b+1], log_data[b+1]}, {32'h4, 32'hDEAD_BEEF});

    // Empty program
    b = log_n;
    load_en_i = 1'b1;
    stream(32'd0, 0);
    finish_load("zero_len", 1'b1, 1'b0);
    chk("zero_len_writes", 64'(log_n - b), 64'(0));

    // Oversize header
    b = log_n;
    load_en_i = 1'b1;
    stream(32'h0000_1001, 0);
    finish_load("oversize", 1'b0, 1'b1);
    chk("oversize_writes", 64'(log_n - b), 64'(0));

    // TI set alongside RI must survive the RI clear
    ti_force = 1'b1;
    wv[0] = $urandom;
    load_en_i = 1'b1;
    stream(32'd1, 1);
    finish_load("ti_keep", 1'b1, 1'b0);
    chk("ti_keep_wdata", 64'(last_uwr), 64'h2);
    ti_force = 1'b0;

    // Abort after six bytes, then a clean reload from address 0
    load_en_i = 1'b1;
    push_word(32'd3);
    push_byte(8'hA5);
    push_byte(8'h5A);
    wait_quiet("abort");
    load_en_i = 1'b0;
    tick();
    chk("abort_next_cycle", 64'({hold_core_o, uart_wr_en_o, rom_wr_en_o, uart_rd_addr_o}), 64'(0));
    repeat (5) tick();
    for (int i = 0; i < 3; i++) wv[i] = $urandom;
    load_en_i = 1'b1;
    stream(32'd3, 3);
    finish_load("after_abort", 1'b1, 1'b0);

    // Reset between byte 2 and byte 3 of the second word, then a fresh stream
    load_en_i = 1'b1;
    wv[0] = $urandom;
    stream(32'd2, 1);
    push_byte(8'h11);
    push_byte(8'h22);
    wait_quiet("midreset");
    chk("midreset_first_word", 64'(exp_wr - exp_rd), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("midreset_async", 64'({hold_core_o, done_o, err_o, uart_rd_addr_o}), 64'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) wv[i] = $urandom;
    stream(32'd2, 2);
    finish_load("after_reset", 1'b1, 1'b0);

    // Random programs
    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) wv[i] = $urandom;
      load_en_i = 1'b1;
      stream(32'(n), n);
      finish_load("random", 1'b1, 1'b0);
    end

    repeat (3) tick();
    sim_end = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
